stdp_pair_controller: RTL and testbench

// - Sequencing front end for the combinational STDP weight-change block: timestamps pre/post spikes, forms t_change, pulses apply, captures dw, updates weight.
// - Sits between one synapse's spike sources and the STDP block; owns the synaptic weight register.
// - Numbers: sign-magnitude fixed point, bit N-1 = sign, Q fractional bits (-0.5 = 32'h8000_8000 at N=32, Q=16).

---
 rtl/stdp_pair_controller.sv | 174 +++++++++++++++++
 tb/tb_stdp_pair_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_pair_controller.sv
// stdp_pair_controller: pairs pre/post spikes, drives t_change/apply to the
// combinational STDP block, captures dw and updates the clamped synaptic weight.
// Optional: define STDP_DROP_CNT_EN to add the saturating drop_cnt output.
module stdp_pair_controller #(
    parameter int unsigned N      = 32,
    parameter int unsigned Q      = 16,
    parameter int unsigned CNT_W  = 15,
    parameter int unsigned WINDOW = 100
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pre_spike,
    input  logic         post_spike,
    input  logic         weight_load,
    input  logic [N-1:0] weight_init,
    input  logic [N-1:0] w_max,
    input  logic [N-1:0] dw,
    output logic [N-1:0] t_change,
    output logic         apply,
    output logic [N-1:0] weight,
    output logic         busy,
    output logic         update_done
`ifdef STDP_DROP_CNT_EN
    ,
    output logic [15:0]  drop_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StApply, StUpdate} state_e;

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W:0]   WindowC = (CNT_W + 1)'(WINDOW);

    state_e           state_q;
    logic [CNT_W-1:0] pre_cnt_q, post_cnt_q;
    logic             seen_pre_q, seen_post_q;
    logic             pend_q;
    logic [N-1:0]     pend_t_q;
    logic [N-1:0]     dw_q;

    // Counters hold edges since the last spike, so the distance from that spike
    // to the current cycle is one more than the stored value.
    logic [CNT_W:0] pre_el, post_el;
    logic [N-1:0]   pre_mag, post_mag;
    logic           ev_valid;
    logic [N-1:0]   ev_t;

    // Pair detection on the current cycle's spikes against the pre-clear counters
    always_comb begin
        pre_el   = {1'b0, pre_cnt_q} + 1'b1;
        post_el  = {1'b0, post_cnt_q} + 1'b1;
        pre_mag  = N'(pre_el) << Q;
        post_mag = N'(post_el) << Q;
        ev_valid = 1'b0;
        ev_t     = '0;
        if (pre_spike && post_spike) begin
            ev_valid = 1'b1;
        end else if (post_spike && seen_pre_q && (pre_el < WindowC)) begin
            ev_valid = 1'b1;
            // Negative zero is normalised to all zeros
            ev_t = (pre_mag[N-2:0] == '0) ? '0 : {1'b1, pre_mag[N-2:0]};
        end else if (pre_spike && seen_post_q && (post_el < WindowC)) begin
            ev_valid = 1'b1;
            ev_t     = {1'b0, post_mag[N-2:0]};
        end
    end

    logic [N-1:0] dw_mag;
    logic [N:0]   sum;
    logic [N-1:0] diff;
    logic [N-1:0] upd_w;

    // Sign-magnitude weight + dw, clamped to [0, w_max]
    always_comb begin
        dw_mag = {1'b0, dw_q[N-2:0]};
        sum    = {1'b0, weight} + {1'b0, dw_mag};
        diff   = weight - dw_mag;
        upd_w  = '0;
        if (!dw_q[N-1]) begin
            upd_w = (sum > {1'b0, w_max}) ? w_max : sum[N-1:0];
        end else if (dw_mag <= weight) begin
            upd_w = (diff > w_max) ? w_max : diff;
        end
    end

    // Counters, pending slot, sequencing FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            seen_pre_q  <= 1'b0;
            seen_post_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_t_q    <= '0;
            dw_q        <= '0;
            t_change    <= '0;
            apply       <= 1'b0;
            weight      <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
`ifdef STDP_DROP_CNT_EN
            drop_cnt    <= '0;
`endif
        end else begin
            pre_cnt_q   <= pre_spike ? '0 :
                           (pre_cnt_q == CntMax) ? pre_cnt_q : pre_cnt_q + 1'b1;
            post_cnt_q  <= post_spike ? '0 :
                           (post_cnt_q == CntMax) ? post_cnt_q : post_cnt_q + 1'b1;
            seen_pre_q  <= seen_pre_q | pre_spike;
            seen_post_q <= seen_post_q | post_spike;
            apply       <= 1'b0;
            update_done <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (ev_valid) begin
                        t_change <= ev_t;
                        apply    <= 1'b1;
                        busy     <= 1'b1;
                        state_q  <= StApply;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                StApply: begin
                    dw_q    <= dw;
                    busy    <= 1'b1;
                    state_q <= StUpdate;
                    if (ev_valid && !pend_q) begin
                        pend_q   <= 1'b1;
                        pend_t_q <= ev_t;
                    end
                end
                StUpdate: begin
                    weight      <= upd_w;
                    update_done <= 1'b1;
                    // A full slot is served first; a new event this cycle is then dropped
                    if (pend_q) begin
                        t_change <= pend_t_q;
                        pend_q   <= 1'b0;
                        apply    <= 1'b1;
                        busy     <= 1'b1;
                        state_q  <= StApply;
                    end else if (ev_valid) begin
                        t_change <= ev_t;
                        apply    <= 1'b1;
                        busy     <= 1'b1;
                        state_q  <= StApply;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase

            // External load overrides the update write
            if (weight_load) begin
                weight <= weight_init;
            end

`ifdef STDP_DROP_CNT_EN
            if (ev_valid && (state_q != StIdle) && pend_q && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_stdp_pair_controller.sv
// Directed bench for stdp_pair_controller with an apply/weight scoreboard.
module tb_stdp_pair_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pre_spike = 1'b0;
    logic        post_spike = 1'b0;
    logic        weight_load = 1'b0;
    logic [31:0] weight_init = '0;
    logic [31:0] w_max = 32'h7FFF_FFFF;
    logic [31:0] dw = 32'h7FFF_FFFF;
    logic [31:0] t_change;
    logic        apply;
    logic [31:0] weight;
    logic        busy;
    logic        update_done;
`ifdef STDP_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    stdp_pair_controller dut (
        .clk         (clk),
        .reset       (reset),
        .pre_spike   (pre_spike),
        .post_spike  (post_spike),
        .weight_load (weight_load),
        .weight_init (weight_init),
        .w_max       (w_max),
        .dw          (dw),
        .t_change    (t_change),
        .apply       (apply),
        .weight      (weight),
        .busy        (busy),
        .update_done (update_done)
`ifdef STDP_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] t;
        logic [31:0] d;
    } apply_exp_t;

    apply_exp_t  exp_apply[$];
    logic [31:0] exp_w[$];
    logic [31:0] model_weight = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_w(input logic [31:0] w, input logic [31:0] d,
                                            input logic [31:0] wmax);
        longint s;
        s = longint'(w) + (d[31] ? -longint'(d[30:0]) : longint'(d[30:0]));
        if (s < 0) s = 0;
        if (s > longint'(wmax)) s = longint'(wmax);
        return 32'(s);
    endfunction

    // Expect one apply with t; the STDP block will answer with d
    task automatic expect_ev(input logic [31:0] t, input logic [31:0] d, input bit upd);
        apply_exp_t e;
        e.t = t;
        e.d = d;
        exp_apply.push_back(e);
        if (upd) begin
            model_weight = model_w(model_weight, d, w_max);
            exp_w.push_back(model_weight);
        end
    endtask

    // Scoreboard: plays the STDP block on apply, checks weight on update_done
    always @(negedge clk) begin
        if (apply === 1'b1) begin
            check("apply_expected", 32'(exp_apply.size() > 0), 32'd1);
            if (exp_apply.size() > 0) begin
                apply_exp_t e;
                e = exp_apply.pop_front();
                check("t_change", t_change, e.t);
                dw = e.d;
            end
        end else begin
            dw = 32'h7FFF_FFFF;
        end
        if (update_done === 1'b1) begin
            check("update_expected", 32'(exp_w.size() > 0), 32'd1);
            if (exp_w.size() > 0) check("weight", weight, exp_w.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic spike(input logic p, input logic q);
        pre_spike  = p;
        post_spike = q;
        tick();
        pre_spike  = 1'b0;
        post_spike = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_weight = '0;
    endtask

    task automatic load(input logic [31:0] v);
        weight_init = v;
        weight_load = 1'b1;
        tick();
        weight_load = 1'b0;
        model_weight = v;
    endtask

    initial begin
        idle(2);
        reset = 1'b0;
        #0;
        check("rst_t_change", t_change, 32'h0);
        check("rst_apply", 32'(apply), 32'h0);
        check("rst_weight", weight, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_update_done", 32'(update_done), 32'h0);

        // Pre then post 5 cycles later: potentiation, with latency checks
        do_reset();
        spike(1'b1, 1'b0);
        idle(4);
        expect_ev(32'h8005_0000, 32'h0000_4000, 1'b1);
        spike(1'b0, 1'b1);
        check("lat_apply_c1", 32'(apply), 32'h1);
        check("lat_t_c1", t_change, 32'h8005_0000);
        tick();
        check("lat_apply_c2", 32'(apply), 32'h0);
        check("lat_busy_c2", 32'(busy), 32'h1);
        tick();
        check("lat_done_c3", 32'(update_done), 32'h1);
        check("lat_weight_c3", weight, 32'h0000_4000);
        tick();
        check("done_one_cycle", 32'(update_done), 32'h0);
        check("t_change_hold", t_change, 32'h8005_0000);
        idle(3);

        // Post then pre 3 cycles later: depression from 1.0
        do_reset();
        load(32'h0001_0000);
        spike(1'b0, 1'b1);
        idle(2);
        expect_ev(32'h0003_0000, 32'h8000_2000, 1'b1);
        spike(1'b1, 1'b0);
        idle(5);
        check("dep_weight", weight, 32'h0000_E000);

        // Simultaneous spikes: t_change 0, dw 0, weight unchanged
        expect_ev(32'h0, 32'h0, 1'b1);
        spike(1'b1, 1'b1);
        idle(5);

        // Window edge: 100 cycles apart gives nothing, 99 pairs
        do_reset();
        spike(1'b1, 1'b0);
        idle(99);
        spike(1'b0, 1'b1);
        check("window_no_apply", 32'(apply), 32'h0);
        idle(4);
        check("window_no_busy", 32'(busy), 32'h0);
        do_reset();
        spike(1'b1, 1'b0);
        idle(98);
        expect_ev(32'h8063_0000, 32'h0, 1'b1);
        spike(1'b0, 1'b1);
        idle(5);

        // Clamping at w_max and at zero
        do_reset();
        w_max = 32'h0002_0000;
        load(32'h0001_8000);
        expect_ev(32'h0, 32'h0001_0000, 1'b1);
        spike(1'b1, 1'b1);
        idle(5);
        check("clamp_hi", weight, 32'h0002_0000);
        expect_ev(32'h0, 32'h8004_0000, 1'b1);
        spike(1'b1, 1'b1);
        idle(5);
        check("clamp_lo", weight, 32'h0);
        w_max = 32'h7FFF_FFFF;

        // Three events on consecutive cycles: two served back to back, third dropped
        do_reset();
        load(32'h0001_0000);
        spike(1'b1, 1'b0);
        idle(1);
        expect_ev(32'h8002_0000, 32'h0000_3000, 1'b1);
        expect_ev(32'h0001_0000, 32'h8000_1000, 1'b1);
        spike(1'b0, 1'b1);
        spike(1'b1, 1'b0);
        spike(1'b0, 1'b1);
        idle(8);
        check("burst_weight", weight, 32'h0001_2000);
`ifdef STDP_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'h1);
`endif

        // Reset while in UPDATE
        do_reset();
        load(32'h0001_0000);
        spike(1'b1, 1'b0);
        idle(1);
        expect_ev(32'h8002_0000, 32'h0000_1000, 1'b0);
        spike(1'b0, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        check("ru_t_change", t_change, 32'h0);
        check("ru_apply", 32'(apply), 32'h0);
        check("ru_weight", weight, 32'h0);
        check("ru_busy", 32'(busy), 32'h0);
        check("ru_update_done", 32'(update_done), 32'h0);
        reset = 1'b0;
        model_weight = '0;
        tick();
        check("ru_no_done", 32'(update_done), 32'h0);
        check("ru_idle", 32'(busy), 32'h0);
        idle(3);

        check("apply_queue_empty", 32'(exp_apply.size()), 32'h0);
        check("weight_queue_empty", 32'(exp_w.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
